// File: rtl/sprite_plotter_if.sv
// -----------------------------------------------------------------------------
// sprite_plotter_if
// Bundles the request, sprite-ROM and framebuffer-write signals of the sprite
// plotter so they travel as one port.
//
//   master : the requester / ROM / framebuffer side
//            drives  start, erase, pos_x, pos_y, fg_color, bg_color, rom_data
//            sees    rom_addr, busy, done, plot, x_out, y_out, color_out
//   slave  : the plotter itself (opposite directions)
// -----------------------------------------------------------------------------
interface sprite_plotter_if #(
   parameter int SPR_W   = 8,
   parameter int ROW_AW  = 4,
   parameter int COLOR_W = 3,
   parameter int X_W     = 8,
   parameter int Y_W     = 7
);
   logic               start;
   logic               erase;
   logic [X_W-1:0]     pos_x;
   logic [Y_W-1:0]     pos_y;
   logic [COLOR_W-1:0] fg_color;
   logic [COLOR_W-1:0] bg_color;
   logic [ROW_AW-1:0]  rom_addr;
   logic [SPR_W-1:0]   rom_data;
   logic               busy;
   logic               done;
   logic               plot;
   logic [X_W-1:0]     x_out;
   logic [Y_W-1:0]     y_out;
   logic [COLOR_W-1:0] color_out;

   modport master (
      output start, erase, pos_x, pos_y, fg_color, bg_color, rom_data,
      input  rom_addr, busy, done, plot, x_out, y_out, color_out
   );

   modport slave (
      input  start, erase, pos_x, pos_y, fg_color, bg_color, rom_data,
      output rom_addr, busy, done, plot, x_out, y_out, color_out
   );
endinterface

// File: rtl/sprite_plotter.sv
// -----------------------------------------------------------------------------
// sprite_plotter
// Renders an SPR_W x SPR_H bitmap from a synchronous sprite ROM into the
// 160x120 framebuffer, one pixel write per cycle. Each row costs two fetch
// cycles followed by SPR_W plot cycles; a single DONE cycle ends the sprite.
// Rows grow upward from the anchor (row r lands on pos_y - r); pixels that fall
// off screen are suppressed but still take their cycle.
//
// Ports:
//   clock     - system clock, rising edge
//   reset     - asynchronous active-high reset
//   bus       - sprite_plotter_if.slave: start/erase/pos/colours request,
//               rom_addr/rom_data sprite ROM port, busy/done status and the
//               plot/x_out/y_out/color_out framebuffer write
//
// Optional build macro:
//   SPRITE_PLOTTER_TRANSPARENT_EN - mask-0 pixels are never written, in either
//                                   mode; cycle count is unchanged.
// -----------------------------------------------------------------------------
module sprite_plotter #(
   parameter int SPR_W    = 8,
   parameter int SPR_H    = 16,
   parameter int ROW_AW   = 4,
   parameter int COLOR_W  = 3,
   parameter int X_W      = 8,
   parameter int Y_W      = 7,
   parameter int SCREEN_W = 160,
   parameter int SCREEN_H = 120
) (
   input  logic           clock,
   input  logic           reset,
   sprite_plotter_if.slave bus
);
   localparam int COL_W = (SPR_W > 1) ? $clog2(SPR_W) : 1;

   typedef enum logic [2:0] {IDLE, FETCH_A, FETCH_D, PLOT, DONE} state_t;
   state_t state_reg, state_next;

   logic [ROW_AW-1:0]  row_reg;
   logic [COL_W-1:0]   col_reg;
   logic [SPR_W-1:0]   shift_reg;
   logic               erase_reg;
   logic [X_W-1:0]     pos_x_reg;
   logic [Y_W-1:0]     pos_y_reg;
   logic [COLOR_W-1:0] fg_reg;
   logic [COLOR_W-1:0] bg_reg;
   logic [ROW_AW-1:0]  rom_addr_reg;
   logic               plot_reg;
   logic [X_W-1:0]     x_out_reg;
   logic [Y_W-1:0]     y_out_reg;
   logic [COLOR_W-1:0] color_out_reg;

   logic               last_col;
   logic               last_row;
   logic               accept;
   logic               pix_en;
   logic [X_W:0]       x_sum;
   logic [Y_W:0]       y_diff;
   logic               on_screen;
   logic               mask;
   logic               pix_write;
   logic [COLOR_W-1:0] pix_color;

   assign last_col = (col_reg == COL_W'(SPR_W - 1));
   assign last_row = (row_reg == ROW_AW'(SPR_H - 1));

   // ---------------- FSM: state register ----------------
   always_ff @(posedge clock or posedge reset) begin
      if (reset)
         state_reg <= IDLE;
      else
         state_reg <= state_next;
   end

   // ---------------- FSM: next state ----------------
   always_comb begin
      state_next = state_reg;
      case (state_reg)
         IDLE:    if (bus.start) state_next = FETCH_A;
         FETCH_A: state_next = FETCH_D;
         FETCH_D: state_next = PLOT;
         PLOT:    if (last_col) state_next = last_row ? DONE : FETCH_A;
         DONE:    state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // ---------------- FSM: outputs ----------------
   always_comb begin
      accept   = 1'b0;
      pix_en   = 1'b0;
      bus.busy = 1'b1;
      bus.done = 1'b0;
      case (state_reg)
         IDLE: begin
            bus.busy = 1'b0;
            accept   = bus.start;
         end
         PLOT:    pix_en   = 1'b1;
         DONE:    bus.done = 1'b1;
         default: ;
      endcase
   end

   // Coordinates are formed one bit wider so that overflow past the right
   // edge and underflow below row 0 show up as a carry/borrow instead of a
   // wrap onto the opposite side of the screen.
   assign x_sum     = {1'b0, pos_x_reg} + (X_W + 1)'(col_reg);
   assign y_diff    = {1'b0, pos_y_reg} - (Y_W + 1)'(row_reg);
   assign on_screen = (x_sum < (X_W + 1)'(SCREEN_W)) && !y_diff[Y_W] &&
                      (y_diff[Y_W-1:0] < Y_W'(SCREEN_H));

   // The row bitmap is shifted left each plot cycle; the MSB is always the
   // mask bit of the current column.
   assign mask      = shift_reg[SPR_W-1];
   assign pix_color = (mask && !erase_reg) ? fg_reg : bg_reg;

`ifdef SPRITE_PLOTTER_TRANSPARENT_EN
   assign pix_write = pix_en && on_screen && mask;
`else
   assign pix_write = pix_en && on_screen;
`endif

   // ---------------- datapath ----------------
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         row_reg       <= '0;
         col_reg       <= '0;
         shift_reg     <= '0;
         erase_reg     <= 1'b0;
         pos_x_reg     <= '0;
         pos_y_reg     <= '0;
         fg_reg        <= '0;
         bg_reg        <= '0;
         rom_addr_reg  <= '0;
         plot_reg      <= 1'b0;
         x_out_reg     <= '0;
         y_out_reg     <= '0;
         color_out_reg <= '0;
      end else begin
         if (accept) begin
            erase_reg    <= bus.erase;
            pos_x_reg    <= bus.pos_x;
            pos_y_reg    <= bus.pos_y;
            fg_reg       <= bus.fg_color;
            bg_reg       <= bus.bg_color;
            row_reg      <= '0;
            rom_addr_reg <= '0;
         end

         // ROM samples rom_addr at the end of FETCH_A; its data is valid
         // throughout FETCH_D and captured here.
         if (state_reg == FETCH_D) begin
            shift_reg <= bus.rom_data;
            col_reg   <= '0;
         end

         if (pix_en) begin
            shift_reg <= shift_reg << 1;
            col_reg   <= col_reg + COL_W'(1);
            // Present the next row address so it is stable during FETCH_A.
            if (last_col && !last_row) begin
               row_reg      <= row_reg + ROW_AW'(1);
               rom_addr_reg <= row_reg + ROW_AW'(1);
            end
         end

         // Write outputs lag the counters by one cycle; coordinates and
         // colour only move on a real write so a clipped pixel never leaves
         // a wrapped coordinate on the bus.
         plot_reg <= pix_write;
         if (pix_write) begin
            x_out_reg     <= x_sum[X_W-1:0];
            y_out_reg     <= y_diff[Y_W-1:0];
            color_out_reg <= pix_color;
         end
      end
   end

   assign bus.rom_addr  = rom_addr_reg;
   assign bus.plot      = plot_reg;
   assign bus.x_out     = x_out_reg;
   assign bus.y_out     = y_out_reg;
   assign bus.color_out = color_out_reg;
endmodule
